// File: rtl/fp_div_seq_if.sv
// fp_div_seq_if: start/done request bus for the sequential floating-point divider.
// The master drives the operands and start; the slave returns status and the registered quotient.
interface fp_div_seq_if #(
    parameter int unsigned NEXP = 5,
    parameter int unsigned NSIG = 10
);
    localparam int unsigned W = NEXP + NSIG + 1;
    localparam int unsigned LAST_FLAG = 6;

    logic                 start;
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic                 busy;
    logic                 done;
    logic [W-1:0]         q;
    logic [LAST_FLAG-1:0] qFlags;

    modport master (output start, a, b, input busy, done, q, qFlags);
    modport slave  (input start, a, b, output busy, done, q, qFlags);
endinterface

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential restoring radix-2 IEEE-754 divider (q = a / b) with constant latency.
// Define FP_DIV_RNE_EN for round-to-nearest-even (one extra cycle); the default build truncates.
module fp_div_seq #(
    parameter int unsigned NEXP = 5,
    parameter int unsigned NSIG = 10
) (
    input logic         clk,
    input logic         rst,
    fp_div_seq_if.slave bus
);
    localparam int unsigned W   = NEXP + NSIG + 1;
    localparam int unsigned EW  = NEXP + 3;
    localparam int unsigned SGW = NSIG + 1;
    localparam int unsigned RW  = NSIG + 2;
`ifdef FP_DIV_RNE_EN
    localparam int unsigned QW  = NSIG + 3;
`else
    localparam int unsigned QW  = NSIG + 2;
`endif
    localparam int unsigned CW  = $clog2(QW);
    localparam int unsigned SW  = $clog2(NSIG + 2);
    localparam int unsigned NFLAG     = 6;
    localparam int unsigned SNAN      = 0;
    localparam int unsigned QNAN      = 1;
    localparam int unsigned INFINITY  = 2;
    localparam int unsigned ZERO      = 3;
    localparam int unsigned SUBNORMAL = 4;
    localparam int unsigned NORMAL    = 5;

    localparam int BIAS = (1 << (NEXP - 1)) - 1;
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] EMAX_E = EW'(BIAS);
    localparam logic signed [EW-1:0] ZLIM_E = EW'(1 - BIAS - int'(NSIG));

    typedef enum logic [2:0] {IDLE, LOAD, DIV, NORM, FIN} stateT;

    stateT                  state, stateNext;
    logic                   busyReg, doneReg;
    logic [W-1:0]           qReg;
    logic [NFLAG-1:0]       qFlagsReg;
    logic [W-1:0]           aReg, bReg;
    logic                   sign;
    logic [SGW-1:0]         bSig;
    logic [RW-1:0]          rem;
    logic [QW-1:0]          qraw;
    logic signed [EW-1:0]   eq;
    logic [CW-1:0]          iterCnt;
    logic                   special;
    logic [W-1:0]           specQ;
    logic [NFLAG-1:0]       specFlags;
    logic [SGW-1:0]         sigR;
    logic signed [EW-1:0]   eR;

    // Position of the leading one as a left-shift amount that restores the hidden bit.
    function automatic logic [SW-1:0] leadShift(input logic [SGW-1:0] s);
        leadShift = '0;
        for (int i = 0; i <= int'(NSIG); i++)
            if (s[i]) leadShift = SW'(int'(NSIG) - i);
    endfunction

    // One restoring step: {quotient bit, shifted partial remainder}.
    function automatic logic [RW:0] divStep(input logic [RW-1:0] r, input logic [SGW-1:0] d);
        logic          ge;
        logic [RW-1:0] diff;
        ge      = r >= RW'(d);
        diff    = ge ? r - RW'(d) : r;
        divStep = {ge, RW'(diff << 1)};
    endfunction

    // Operand classification from the captured operands.
    logic [NEXP-1:0] aExp, bExp;
    logic [NSIG-1:0] aFrac, bFrac;
    logic aNan, bNan, aSnan, bSnan, aQnan, bQnan, aInf, bInf, aZero, bZero;

    assign aExp  = aReg[W-2:NSIG];
    assign bExp  = bReg[W-2:NSIG];
    assign aFrac = aReg[NSIG-1:0];
    assign bFrac = bReg[NSIG-1:0];
    assign aNan  = (&aExp) & (|aFrac);
    assign bNan  = (&bExp) & (|bFrac);
    assign aSnan = aNan & ~aFrac[NSIG-1];
    assign bSnan = bNan & ~bFrac[NSIG-1];
    assign aQnan = aNan & aFrac[NSIG-1];
    assign bQnan = bNan & bFrac[NSIG-1];
    assign aInf  = (&aExp) & ~(|aFrac);
    assign bInf  = (&bExp) & ~(|bFrac);
    assign aZero = ~(|aExp) & ~(|aFrac);
    assign bZero = ~(|bExp) & ~(|bFrac);

    // Subnormal operands are normalised so the divider always sees a set hidden bit.
    logic [SW-1:0]        aShift, bShift;
    logic [SGW-1:0]       aSigRaw, bSigRaw, aSigN, bSigN;
    logic signed [EW-1:0] aE, bE;
    logic [RW:0]          firstStep, iterStep;

    always_comb begin
        aSigRaw   = {|aExp, aFrac};
        bSigRaw   = {|bExp, bFrac};
        aShift    = leadShift(aSigRaw);
        bShift    = leadShift(bSigRaw);
        aSigN     = SGW'(aSigRaw << aShift);
        bSigN     = SGW'(bSigRaw << bShift);
        aE        = $signed(EW'((aExp == '0) ? NEXP'(1) : aExp)) - BIAS_E - $signed(EW'(aShift));
        bE        = $signed(EW'((bExp == '0) ? NEXP'(1) : bExp)) - BIAS_E - $signed(EW'(bShift));
        firstStep = divStep(RW'(aSigN), bSigN);
        iterStep  = divStep(rem, bSig);
    end

    // Special-operand result, resolved in LOAD and held until FIN.
    logic             specHit;
    logic [W-1:0]     specVal;
    logic [NFLAG-1:0] specFl;

    always_comb begin
        specHit = 1'b1;
        specVal = {sign, {(W-1){1'b0}}};
        specFl  = '0;
        if (aSnan) begin
            specVal = aReg;
            specFl[SNAN] = 1'b1;
        end else if (bSnan) begin
            specVal = bReg;
            specFl[SNAN] = 1'b1;
        end else if (aQnan) begin
            specVal = aReg;
            specFl[QNAN] = 1'b1;
        end else if (bQnan) begin
            specVal = bReg;
            specFl[QNAN] = 1'b1;
        end else if ((aInf & bInf) | (aZero & bZero)) begin
            specVal = {sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
            specFl[QNAN] = 1'b1;
        end else if (aInf | bZero) begin
            specVal = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
            specFl[INFINITY] = 1'b1;
        end else if (aZero | bInf) begin
            specFl[ZERO] = 1'b1;
        end else begin
            specHit = 1'b0;
        end
    end

    // Normalise the raw quotient: its leading one sits at weight 2^0 or 2^-1.
    logic [SGW-1:0]       sigN;
    logic signed [EW-1:0] eN;

`ifdef FP_DIV_RNE_EN
    logic [SGW-1:0]       keep;
    logic                 guardBit, stickyBit;
    logic [SGW:0]         rounded;
    logic signed [EW-1:0] eBase;

    always_comb begin
        keep      = qraw[QW-1] ? qraw[QW-1:2] : qraw[QW-2:1];
        guardBit  = qraw[QW-1] ? qraw[1] : qraw[0];
        stickyBit = (|rem) | (qraw[QW-1] & qraw[0]);
        eBase     = qraw[QW-1] ? eq : eq - ONE_E;
        rounded   = {1'b0, keep} + (SGW+1)'(guardBit & (stickyBit | keep[0]));
        if (rounded[SGW]) begin
            sigN = rounded[SGW:1];
            eN   = eBase + ONE_E;
        end else begin
            sigN = rounded[SGW-1:0];
            eN   = eBase;
        end
    end
`else
    always_comb begin
        sigN = qraw[QW-1] ? qraw[QW-1:1] : qraw[QW-2:0];
        eN   = qraw[QW-1] ? eq : eq - ONE_E;
    end
`endif

    // Range the exponent into zero, subnormal, infinity or normal.
    logic [W-1:0]     finQ;
    logic [NFLAG-1:0] finFlags;
    logic [EW-1:0]    shamt;

    always_comb begin
        shamt    = EW'(EMIN_E - eR);
        finQ     = {sign, {(W-1){1'b0}}};
        finFlags = '0;
        if (special) begin
            finQ     = specQ;
            finFlags = specFlags;
        end else if (eR < ZLIM_E) begin
            finFlags[ZERO] = 1'b1;
        end else if (eR < EMIN_E) begin
            finQ = {sign, {NEXP{1'b0}}, NSIG'(sigR >> shamt)};
            finFlags[SUBNORMAL] = 1'b1;
        end else if (eR > EMAX_E) begin
            finQ = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
            finFlags[INFINITY] = 1'b1;
        end else begin
            finQ = {sign, NEXP'(eR + BIAS_E), sigR[NSIG-1:0]};
            finFlags[NORMAL] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (bus.start) stateNext = LOAD;
            LOAD:    stateNext = DIV;
            DIV:     if (iterCnt == '0) stateNext = NORM;
            NORM:    stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath; LOAD also performs the first restoring step so latency stays NSIG+4.
    always_ff @(posedge clk) begin
        if (rst) begin
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            qReg      <= '0;
            qFlagsReg <= '0;
            aReg      <= '0;
            bReg      <= '0;
            sign      <= 1'b0;
            bSig      <= '0;
            rem       <= '0;
            qraw      <= '0;
            eq        <= '0;
            iterCnt   <= '0;
            special   <= 1'b0;
            specQ     <= '0;
            specFlags <= '0;
            sigR      <= '0;
            eR        <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    aReg    <= bus.a;
                    bReg    <= bus.b;
                    sign    <= bus.a[W-1] ^ bus.b[W-1];
                    busyReg <= 1'b1;
                end
                LOAD: begin
                    bSig      <= bSigN;
                    rem       <= firstStep[RW-1:0];
                    qraw      <= QW'(firstStep[RW]);
                    eq        <= aE - bE;
                    iterCnt   <= CW'(QW - 2);
                    special   <= specHit;
                    specQ     <= specVal;
                    specFlags <= specFl;
                end
                DIV: begin
                    rem     <= iterStep[RW-1:0];
                    qraw    <= {qraw[QW-2:0], iterStep[RW]};
                    iterCnt <= iterCnt - CW'(1);
                end
                NORM: begin
                    sigR <= sigN;
                    eR   <= eN;
                end
                FIN: begin
                    qReg      <= finQ;
                    qFlagsReg <= finFlags;
                    doneReg   <= 1'b1;
                    busyReg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
    assign bus.q      = qReg;
    assign bus.qFlags = qFlagsReg;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: table-driven scoreboard bench for fp_div_seq (half precision defaults).
// Expected results and done cycles are queued at start and checked when done pulses.
module tb_fp_div_seq;
`ifdef FP_DIV_RNE_EN
    localparam int LAT = 15;
`else
    localparam int LAT = 14;
`endif
    localparam logic [5:0] F_SNAN = 6'b000001;
    localparam logic [5:0] F_QNAN = 6'b000010;
    localparam logic [5:0] F_INF  = 6'b000100;
    localparam logic [5:0] F_ZERO = 6'b001000;
    localparam logic [5:0] F_SUB  = 6'b010000;
    localparam logic [5:0] F_NORM = 6'b100000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [5:0]  f;
    } vecT;

    typedef struct {
        logic [15:0] q;
        logic [5:0]  f;
        int          cyc;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   doneCount = 0;
    expT  sb[$];
    vecT  vecs[$];
    expT  cur;

    fp_div_seq_if bus ();
    fp_div_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest pending operation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected done: q=0x%0h with no operation pending", bus.q);
            end else begin
                cur = sb.pop_front();
                check("q", 32'(bus.q), 32'(cur.q));
                check("qFlags", 32'(bus.qFlags), 32'(cur.f));
                check("latency", 32'(cyc), 32'(cur.cyc));
                check("busy at done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic addV(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q, input logic [5:0] f);
        vecT v;
        v.a = a; v.b = b; v.q = q; v.f = f;
        vecs.push_back(v);
    endtask

    // Called at a negedge where start is being raised; acceptance is at the next posedge.
    task automatic pushExp(input logic [15:0] q, input logic [5:0] f);
        expT e;
        e.q = q; e.f = f; e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
    endtask

    task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q, input logic [5:0] f);
        int g;
        g = 0;
        while (bus.busy && g < 3 * LAT) begin
            @(negedge clk);
            g++;
        end
        bus.start = 1'b1; bus.a = a; bus.b = b;
        pushExp(q, f);
        @(negedge clk);
        bus.start = 1'b0;
        g = 0;
        while (sb.size() != 0 && g < LAT + 10) begin
            @(negedge clk);
            g++;
        end
        check("op completed", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int g;
        int base;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;

        addV(16'h4200, 16'h3E00, 16'h4000, F_NORM);
        addV(16'h3C00, 16'h0000, 16'h7C00, F_INF);
        addV(16'h0000, 16'h0000, 16'h7E00, F_QNAN);
        addV(16'h7D00, 16'h7E00, 16'h7D00, F_SNAN);
        addV(16'h7BFF, 16'h3800, 16'h7C00, F_INF);
        addV(16'h0400, 16'h4400, 16'h0100, F_SUB);
        addV(16'h3C00, 16'h4200, 16'h3555, F_NORM);
        addV(16'h3C00, 16'h3A00, 16'h3D55, F_NORM);
        addV(16'h7E00, 16'h7D00, 16'h7D00, F_SNAN);
        addV(16'h3C00, 16'h7C01, 16'h7C01, F_SNAN);
        addV(16'h7E01, 16'hFE00, 16'h7E01, F_QNAN);
        addV(16'h7E00, 16'h0000, 16'h7E00, F_QNAN);
        addV(16'h7C00, 16'h7C00, 16'h7E00, F_QNAN);
        addV(16'hFC00, 16'h3C00, 16'hFC00, F_INF);
        addV(16'h3C00, 16'h8000, 16'hFC00, F_INF);
        addV(16'h8000, 16'h7C00, 16'h8000, F_ZERO);
        addV(16'h3C00, 16'hFC00, 16'h8000, F_ZERO);
        addV(16'h0000, 16'h4500, 16'h0000, F_ZERO);
        addV(16'hC000, 16'h3C00, 16'hC000, F_NORM);
        addV(16'hBC00, 16'h4200, 16'hB555, F_NORM);
        addV(16'h0001, 16'h0001, 16'h3C00, F_NORM);
        addV(16'h0200, 16'h3C00, 16'h0200, F_SUB);
        addV(16'h0400, 16'h4000, 16'h0200, F_SUB);
        addV(16'h0001, 16'h3C00, 16'h0001, F_SUB);
        addV(16'h0001, 16'h7800, 16'h0000, F_ZERO);
        addV(16'h7800, 16'h3C00, 16'h7800, F_NORM);
        addV(16'h7BFF, 16'h3C00, 16'h7BFF, F_NORM);
        addV(16'h3C00, 16'h0001, 16'h7C00, F_INF);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset q", 32'(bus.q), 32'd0);
        check("reset qFlags", 32'(bus.qFlags), 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            runOp(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f);

        // Abort: ignored re-start while busy, then reset mid-operation.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h3C00; bus.b = 16'h4200;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy after start", 32'(bus.busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h4200; bus.b = 16'h3E00;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy before abort", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort q", 32'(bus.q), 32'd0);
        check("abort qFlags", 32'(bus.qFlags), 32'd0);
        base = doneCount;
        repeat (LAT + 6) @(negedge clk);
        check("no done after abort", 32'(doneCount - base), 32'd0);
        check("idle after abort", 32'(bus.busy), 32'd0);
        runOp(16'h4200, 16'h3E00, 16'h4000, F_NORM);

        // Back-to-back with start held high; new operands presented in each done cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.a = vecs[0].a; bus.b = vecs[0].b;
        pushExp(vecs[0].q, vecs[0].f);
        for (int i = 1; i <= 4; i++) begin
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!bus.done && g < LAT + 5);
            check("b2b done seen", 32'(bus.done), 32'd1);
            if (i < 4) begin
                bus.a = vecs[i + 2].a; bus.b = vecs[i + 2].b;
                pushExp(vecs[i + 2].q, vecs[i + 2].f);
            end else begin
                bus.start = 1'b0;
            end
        end
        repeat (LAT + 5) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        check("idle at end", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
